// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic prescale_ok(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_par_chk.sv
// Expected parity bit for the assembled data byte (even when par_typ_i is 0).
module uart_rx_par_chk #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              par_typ_i,
  output logic              par_exp_o
);

  assign par_exp_o = (^data_i) ^ par_typ_i;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: walks start/data/parity/stop using the
// external edge/bit counter and sampler, and presents validated bytes.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic [5:0]        Prescale,
  input  logic [4:0]        edge_cnt,
  input  logic [3:0]        bit_cnt,
  input  logic              sampled_bit,
  output logic              cnt_enable,
  output logic              reset_count,
  output logic              dat_samp_en,
  output logic [DATA_W-1:0] P_DATA,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err
);

  rx_state_t         state_q;
  logic [5:0]        pre_q;
  logic              par_en_q;
  logic              par_typ_q;
  logic [DATA_W-1:0] shreg_q;
  logic              par_bad_q;
  logic              par_exp;
  logic [5:0]        last_edge;
  logic              bit_end;

  uart_rx_par_chk #(.DATA_W(DATA_W)) u_par_chk (
    .data_i    (shreg_q),
    .par_typ_i (par_typ_q),
    .par_exp_o (par_exp)
  );

  // Frame timing uses the prescale captured at frame start, not the live input.
  assign last_edge = pre_q - 6'd1;
  assign bit_end   = (state_q != IDLE) && ({1'b0, edge_cnt} == last_edge);

  // NOTE: every register here, including the data shift register, is reset
  // asynchronously so an aborted frame leaves no stale state behind.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      pre_q       <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      shreg_q     <= '0;
      par_bad_q   <= 1'b0;
      cnt_enable  <= 1'b0;
      reset_count <= 1'b0;
      dat_samp_en <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; the strobes default low and are
      // raised by the state that owns them.
      data_valid  <= 1'b0;
      reset_count <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!RX_IN && prescale_ok(Prescale)) begin
            state_q     <= START;
            pre_q       <= Prescale;
            par_en_q    <= PAR_EN;
            par_typ_q   <= PAR_TYP;
            reset_count <= 1'b1;
            cnt_enable  <= 1'b1;
            dat_samp_en <= 1'b1;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            par_bad_q   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            if (!sampled_bit) begin
              state_q <= DATA;
            end else begin
              state_q     <= IDLE;
              cnt_enable  <= 1'b0;
              dat_samp_en <= 1'b0;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg_q <= {sampled_bit, shreg_q[DATA_W-1:1]};
            if (bit_cnt == 4'(DATA_W)) begin
              state_q <= par_en_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            par_bad_q <= (sampled_bit != par_exp);
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            stp_err     <= ~sampled_bit;
            par_err     <= par_bad_q;
            if (sampled_bit && !par_bad_q) begin
              P_DATA     <= shreg_q;
              data_valid <= 1'b1;
            end
            state_q     <= IDLE;
            cnt_enable  <= 1'b0;
            dat_samp_en <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_enable  <= 1'b0;
          dat_samp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a behavioural counter and sampler.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = PAR_EVEN;
  logic [5:0] prescale = PRESCALE_8;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       cnt_enable, reset_count, dat_samp_en, data_valid, par_err, stp_err;
  logic [7:0] p_data;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_valid_cyc = 0;
  int frame_start_cyc = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_ctrl #(.DATA_W(8)) dut (
    .CLK         (clk),
    .RST         (rst_n),
    .RX_IN       (rx),
    .PAR_EN      (par_en),
    .PAR_TYP     (par_typ),
    .Prescale    (prescale),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .sampled_bit (sampled_bit),
    .cnt_enable  (cnt_enable),
    .reset_count (reset_count),
    .dat_samp_en (dat_samp_en),
    .P_DATA      (p_data),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  // Edge/bit counter model: held clear while disabled, reset_count clears the bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!cnt_enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if ({1'b0, edge_cnt} == prescale - 6'd1) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 5'd1;
      end
      if (reset_count) bit_cnt <= '0;
    end
  end

  // Sampler model: captures the line mid-bit, stable well before the bit end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sampled_bit <= 1'b1;
    else if (dat_samp_en && ({1'b0, edge_cnt} == (prescale >> 1))) sampled_bit <= rx;
  end

  // Scoreboard consumer: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      strobe_cnt++;
      last_valid_cyc = cyc;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_strobe: P_DATA=%h, expected no strobe", p_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (p_data !== e) $display("FAIL strobe_data: P_DATA=%h, expected %h", p_data, e);
        else n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_gap(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [5:0] p, input logic pe,
                            input logic pt, input logic par_flip, input logic stop_b,
                            input logic good);
    prescale = p;
    par_en   = pe;
    par_typ  = pt;
    if (good) exp_q.push_back(d);
    frame_start_cyc = cyc;
    drive_bit(1'b0, int'(p));
    for (int i = 0; i < 8; i++) drive_bit(d[i], int'(p));
    if (pe) drive_bit((^d) ^ pt ^ par_flip, int'(p));
    drive_bit(stop_b, int'(p));
    rx = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({cnt_enable, reset_count, dat_samp_en, data_valid, par_err, stp_err, p_data} !== 14'h0)
      $display("FAIL reset_outputs: got %h, expected 0",
               {cnt_enable, reset_count, dat_samp_en, data_valid, par_err, stp_err, p_data});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    idle_gap(4);
    n_total++;
    if (cnt_enable !== 1'b0) $display("FAIL idle_after_reset: cnt_enable=%b, expected 0", cnt_enable);
    else n_pass++;
  endtask

  task automatic test_basic();
    int s0, lat;
    s0 = strobe_cnt;
    send_frame(8'hA5, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    lat = frame_start_cyc;
    idle_gap(12);
    n_total++;
    if (strobe_cnt - s0 !== 1) $display("FAIL basic_strobes: got %0d, expected 1", strobe_cnt - s0);
    else n_pass++;
    n_total++;
    if (last_valid_cyc - lat !== 81) $display("FAIL basic_latency: got %0d, expected 81", last_valid_cyc - lat);
    else n_pass++;
    n_total++;
    if ({par_err, stp_err} !== 2'b00) $display("FAIL basic_errs: got %b, expected 00", {par_err, stp_err});
    else n_pass++;
    n_total++;
    if (p_data !== 8'hA5) $display("FAIL basic_pdata: got %h, expected a5", p_data);
    else n_pass++;
  endtask

  task automatic test_parity_err();
    int s0;
    s0 = strobe_cnt;
    send_frame(8'h3C, PRESCALE_16, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0);
    idle_gap(20);
    n_total++;
    if ({par_err, stp_err} !== 2'b10) $display("FAIL parity_errs: got %b, expected 10", {par_err, stp_err});
    else n_pass++;
    n_total++;
    if (strobe_cnt != s0) $display("FAIL parity_strobes: got %0d, expected 0", strobe_cnt - s0);
    else n_pass++;
    n_total++;
    if (p_data !== 8'hA5) $display("FAIL parity_pdata_kept: got %h, expected a5", p_data);
    else n_pass++;
  endtask

  task automatic test_stop_err();
    int s0;
    s0 = strobe_cnt;
    send_frame(8'h00, PRESCALE_32, 1'b1, PAR_ODD, 1'b0, 1'b0, 1'b0);
    idle_gap(36);
    n_total++;
    if ({par_err, stp_err} !== 2'b01) $display("FAIL stop_errs: got %b, expected 01", {par_err, stp_err});
    else n_pass++;
    n_total++;
    if (strobe_cnt != s0) $display("FAIL stop_strobes: got %0d, expected 0", strobe_cnt - s0);
    else n_pass++;
    fork
      send_frame(8'h5A, PRESCALE_32, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b1);
      begin
        repeat (3) @(negedge clk);
        n_total++;
        if ({cnt_enable, stp_err} !== 2'b10)
          $display("FAIL stop_cleared_at_start: {cnt_enable,stp_err}=%b, expected 10", {cnt_enable, stp_err});
        else n_pass++;
      end
    join
    idle_gap(36);
    n_total++;
    if (p_data !== 8'h5A) $display("FAIL stop_next_good: got %h, expected 5a", p_data);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int s0, en_cnt, rc_cnt;
    s0 = strobe_cnt;
    en_cnt = 0;
    rc_cnt = 0;
    prescale = PRESCALE_8;
    par_en = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) rx = 1'b1;
      en_cnt += int'(cnt_enable);
      rc_cnt += int'(reset_count);
    end
    n_total++;
    if (en_cnt != 8) $display("FAIL glitch_start_len: got %0d cycles, expected 8", en_cnt);
    else n_pass++;
    n_total++;
    if (rc_cnt != 1) $display("FAIL glitch_reset_count: got %0d cycles, expected 1", rc_cnt);
    else n_pass++;
    n_total++;
    if ({cnt_enable, dat_samp_en} !== 2'b00 || strobe_cnt != s0)
      $display("FAIL glitch_idle: en=%b samp=%b strobes=%0d, expected 0 0 0",
               cnt_enable, dat_samp_en, strobe_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = strobe_cnt;
    send_frame(8'h55, PRESCALE_32, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    send_frame(8'hAA, PRESCALE_32, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    idle_gap(40);
    n_total++;
    if (strobe_cnt - s0 != 2) $display("FAIL b2b_strobes: got %0d, expected 2", strobe_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int s0;
    prescale = PRESCALE_16;
    par_en = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    drive_bit(1'b0, 8);
    n_total++;
    if (cnt_enable !== 1'b1) $display("FAIL midreset_active: cnt_enable=%b, expected 1", cnt_enable);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({cnt_enable, reset_count, dat_samp_en, data_valid, par_err, stp_err, p_data} !== 14'h0)
      $display("FAIL midreset_outputs: got %h, expected 0",
               {cnt_enable, reset_count, dat_samp_en, data_valid, par_err, stp_err, p_data});
    else n_pass++;
    rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_gap(4);
    s0 = strobe_cnt;
    send_frame(8'h81, PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    idle_gap(20);
    n_total++;
    if (strobe_cnt - s0 != 1 || p_data !== 8'h81)
      $display("FAIL midreset_recover: strobes=%0d P_DATA=%h, expected 1 81", strobe_cnt - s0, p_data);
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drained: %0d left, expected 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
